// File: rtl/mod_arith_pkg.sv
// Shared encodings for the modular-arithmetic sequencer and its instruction decoder:
// opcodes, error codes, FSM state encoding and small counter helpers.
package mod_arith_pkg;

  localparam int ITER_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_RUN  = 3'd2,
    ST_CLR  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef logic [1:0] inst_op_t;
  localparam inst_op_t INST_MUL_INIT = 2'b00;
  localparam inst_op_t INST_DIV_INIT = 2'b01;
  localparam inst_op_t INST_NEXT     = 2'b10;
  localparam inst_op_t INST_CLEAR    = 2'b11;

  typedef logic [1:0] err_t;
  localparam err_t ERR_OK      = 2'b00;
  localparam err_t ERR_TIMEOUT = 2'b01;
  localparam err_t ERR_ABORT   = 2'b10;

  // Iteration count sticks at all-ones rather than wrapping.
  function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
    return (&v) ? v : v + {{(ITER_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic inst_op_t init_op(input logic div_mode);
    return div_mode ? INST_DIV_INIT : INST_MUL_INIT;
  endfunction

endpackage

// File: rtl/mod_arith_seq.sv
// Sequencer for one modular multiply/divide: issues INIT, a stream of NEXT steps,
// then CLEAR, with timeout and abort handling and a one-cycle done pulse.
module mod_arith_seq #(
  parameter logic [9:0] MAX_ITER = 10'd300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  input  logic       dp_stall,
  input  logic       inst_last,
  output logic [1:0] inst_op,
  output logic       inst_en,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic [9:0] iter_cnt
);
  import mod_arith_pkg::*;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  err_t              err_q, err_d;

  // Instruction decode; an abort cycle never issues an instruction.
  always_comb begin
    inst_op = INST_CLEAR;
    inst_en = 1'b0;
    case (state_q)
      ST_INIT: begin
        inst_op = init_op(mode_q);
        inst_en = !dp_stall && !abort;
      end
      ST_RUN: begin
        inst_op = INST_NEXT;
        inst_en = !dp_stall && !abort;
      end
      ST_CLR: begin
        inst_op = INST_CLEAR;
        inst_en = 1'b1;
      end
      default: begin
        inst_op = INST_CLEAR;
        inst_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    iter_cnt_d = iter_cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d     = mode;
          iter_cnt_d = '0;
          err_d      = ERR_OK;
          state_d    = ST_INIT;
        end
      end
      ST_INIT: begin
        if (abort) begin
          err_d   = ERR_ABORT;
          state_d = ST_CLR;
        end else if (!dp_stall) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          err_d   = ERR_ABORT;
          state_d = ST_CLR;
        end else if (!dp_stall) begin
          iter_cnt_d = sat_inc(iter_cnt_q);
          // A final step wins over the timeout when both land on the same NEXT.
          if (inst_last) begin
            state_d = ST_CLR;
          end else if (iter_cnt_d == MAX_ITER) begin
            err_d   = ERR_TIMEOUT;
            state_d = ST_CLR;
          end
        end
      end
      ST_CLR:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      iter_cnt_q <= '0;
      err_q      <= ERR_OK;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      iter_cnt_q <= iter_cnt_d;
      err_q      <= err_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign iter_cnt = iter_cnt_q;

endmodule

// File: doc/mod_arith_seq.md
MOD_ARITH_SEQ -- requirements
Module: mod_arith_seq

Interface
REQ-001 SHALL have parameter MAX_ITER, default 10'd300: max accepted NEXT instructions before timeout.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request one modular operation; sampled only in IDLE.
REQ-005 SHALL have port mode  input  1  0 = multiply, 1 = divide; sampled with start.
REQ-006 SHALL have port abort  input  1  terminate the running operation.
REQ-007 SHALL have port dp_stall  input  1  datapath cannot accept an instruction this cycle.
REQ-008 SHALL have port inst_last  input  1  decoder flag: the current NEXT is the final step.
REQ-009 SHALL have port inst_op  output  2  decoder opcode: 00 MUL_INIT, 01 DIV_INIT, 10 NEXT, 11 CLEAR.
REQ-010 SHALL have port inst_en  output  1  decoder register enable.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  2  00 ok, 01 timeout, 10 abort; valid with done, held until next accepted start.
REQ-014 SHALL have port iter_cnt  output  10  number of NEXT instructions accepted in the current or last operation.

Function
REQ-015 SHALL implement FSM states IDLE, INIT, RUN, CLR, DONE.
REQ-016 In IDLE, start=1 SHALL latch mode, clear iter_cnt and err, and move to INIT on the next edge.
REQ-017 In INIT: inst_op = mode ? 01 : 00 and inst_en = !dp_stall. Move to RUN on the first cycle with dp_stall=0.
REQ-018 In RUN: inst_op = 10 and inst_en = !dp_stall. Each cycle with inst_en=1 is an accepted NEXT and increments iter_cnt, saturating at 1023.
REQ-019 In RUN, an accepted NEXT with inst_last=1 SHALL move to CLR with err unchanged (00).
REQ-020 In RUN, an accepted NEXT that brings iter_cnt to MAX_ITER with inst_last=0 SHALL set err=01 and move to CLR.
REQ-021 In RUN, inst_last SHALL be ignored when inst_en=0.
REQ-022 In CLR: inst_op = 11 and inst_en = 1 regardless of dp_stall. Move to DONE after exactly one cycle.
REQ-023 In DONE: done = 1 for one cycle, inst_en = 0, then move to IDLE.
REQ-024 In IDLE and DONE: inst_en = 0 and inst_op = 11.
REQ-025 inst_op and inst_en SHALL be combinational decodes of the state and dp_stall. busy, done, err and iter_cnt SHALL be registered or pure state decodes.
REQ-026 abort=1 in INIT or RUN SHALL set err=10 and move to CLR. In that cycle inst_en = 0 and iter_cnt does not increment.
REQ-027 abort SHALL be ignored in IDLE, CLR and DONE.
REQ-028 If start and abort are both high in IDLE, start SHALL be accepted.
REQ-029 If abort and an accepted inst_last coincide, abort SHALL take priority (err=10).
REQ-030 start while busy=1 SHALL be ignored; no queuing.
REQ-031 Unstalled latency: start at cycle 0, INIT at cycle 1, NEXT at cycles 2..N+1, CLR at N+2, done at N+3, where N is the accepted NEXT count.

Reset
REQ-032 rst_n=0 SHALL force IDLE asynchronously: inst_en=0, inst_op=11, busy=0, done=0, err=00, iter_cnt=0, latched mode=0.
REQ-033 Reset asserted mid-operation SHALL abandon the operation without issuing CLR or pulsing done.

Structure
REQ-034 Opcodes (INST_MUL_INIT/DIV_INIT/NEXT/CLEAR), err codes and the FSM state encoding SHALL live in shared package mod_arith_pkg, used by the decoder as well.
REQ-035 The design SHALL be a single module with no sub-module. The iteration counter SHALL be inline.

Verification
REQ-036 mode=0, no stall, inst_last on the 4th NEXT -> ops 00,10,10,10,10,11; done at cycle 7; iter_cnt=4; err=00.
REQ-037 mode=1, dp_stall high for 3 cycles in INIT and 2 cycles mid-RUN -> DIV_INIT held until accepted; iter_cnt counts only accepted NEXTs; err=00.
REQ-038 MAX_ITER=5, inst_last never asserted -> 5 NEXTs accepted, then CLR, then done with err=01 and iter_cnt=5.
REQ-039 abort on the 3rd RUN cycle, coincident with inst_last -> inst_en=0 that cycle, CLR next, err=10, iter_cnt=2.
REQ-040 rst_n low during RUN -> immediate IDLE with all outputs at reset values and no done; a new start then completes normally.
REQ-041 start pulsed during RUN and DONE -> ignored; exactly one done per accepted start.
